// File: rtl/gen_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : gen_scheduler_if
// Description : Signal bundle between the front-panel buttons, the generation
//               scheduler and the life datapath it commands.
//   run_btn    : debounced level, rising edge toggles run/pause
//   step_btn   : debounced level, rising edge requests one generation (paused)
//   stamp_btn  : debounced level, rising edge requests one pattern stamp
//   faster_btn : debounced level, rising edge raises speed one level
//   slower_btn : debounced level, rising edge lowers speed one level
//   draw       : active-low one-cycle stamp command
//   freeze     : active-low one-cycle evolve command
//   running    : high while in RUN
//   speed      : current speed level, 0 slowest .. 7 fastest
//   generation : evolve pulses issued since reset (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface gen_scheduler_if #(
  parameter int GEN_W = 16
);
  logic             run_btn;
  logic             step_btn;
  logic             stamp_btn;
  logic             faster_btn;
  logic             slower_btn;
  logic             draw;
  logic             freeze;
  logic             running;
  logic [2:0]       speed;
  logic [GEN_W-1:0] generation;

  // Button/datapath side
  modport master (
    output run_btn, step_btn, stamp_btn, faster_btn, slower_btn,
    input  draw, freeze, running, speed, generation
  );

  // Scheduler side
  modport slave (
    input  run_btn, step_btn, stamp_btn, faster_btn, slower_btn,
    output draw, freeze, running, speed, generation
  );
endinterface
`default_nettype wire

// File: rtl/gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gen_scheduler
// Description : Generation scheduler for a cellular-automaton datapath.
//               Turns five asynchronous button levels into run/pause control,
//               a speed-scaled tick timer and one-cycle draw/freeze commands.
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous, active-low reset
//   bus  : gen_scheduler_if.slave (buttons in, commands/status out)
//   BASE_DIV : clock cycles per speed unit (1 .. 2^24-1)
//   GEN_W    : generation counter width (must match the interface GEN_W)
// Revision    : 1.0 - initial release
// ============================================================================
module gen_scheduler #(
  parameter int BASE_DIV = 1000000,
  parameter int GEN_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  gen_scheduler_if.slave bus
);

  // 27 bits holds BASE_DIV*8 for the largest legal BASE_DIV without loss.
  localparam int                 c_TMR_W = 27;
  localparam logic [c_TMR_W-1:0] c_BASE  = c_TMR_W'(BASE_DIV);

  // Button bit positions in the synchronizer vectors
  localparam int c_B_RUN    = 0;
  localparam int c_B_STEP   = 1;
  localparam int c_B_STAMP  = 2;
  localparam int c_B_FASTER = 3;
  localparam int c_B_SLOWER = 4;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVOLVE = 2'd1,
    STAMP  = 2'd2
  } cmd_t;

  // --------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors
  // --------------------------------------------------------------------------
  logic [4:0] w_btn;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [4:0] prev_q;
  logic [2:0] warm_q;
  logic [4:0] w_ev;

  assign w_btn = {bus.slower_btn, bus.faster_btn, bus.stamp_btn,
                  bus.step_btn, bus.run_btn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= w_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[1:0], 1'b1};
    end
  end

  // The pipeline flops come out of reset as 0, which would make a button held
  // through reset release look like a fresh edge. warm_q[2] only rises once
  // prev_q holds a genuine sample of the pin, so that false edge is masked.
  assign w_ev = sync2_q & ~prev_q & {5{warm_q[2]}};

  logic w_ev_run;
  logic w_ev_step;
  logic w_ev_stamp;
  logic w_ev_faster;
  logic w_ev_slower;

  assign w_ev_run    = w_ev[c_B_RUN];
  assign w_ev_step   = w_ev[c_B_STEP];
  assign w_ev_stamp  = w_ev[c_B_STAMP];
  assign w_ev_faster = w_ev[c_B_FASTER];
  assign w_ev_slower = w_ev[c_B_SLOWER];

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  ctrl_t              ctrl_q,  ctrl_d;
  cmd_t               cmd_q,   cmd_d;
  logic [2:0]         speed_q, speed_d;
  logic [c_TMR_W-1:0] tmr_q,   tmr_d;
  logic               tick_q,  tick_d;
  logic               step_q,  step_d;
  logic               stamp_q, stamp_d;
  logic [GEN_W-1:0]   gen_q,   gen_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= PAUSE;
      cmd_q   <= IDLE;
      speed_q <= 3'd3;
      tmr_q   <= '0;
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
      stamp_q <= 1'b0;
      gen_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cmd_q   <= cmd_d;
      speed_q <= speed_d;
      tmr_q   <= tmr_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      stamp_q <= stamp_d;
      gen_q   <= gen_d;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM, speed and tick timer
  // --------------------------------------------------------------------------
  logic [3:0]         w_mult;
  logic [c_TMR_W-1:0] w_period;
  logic [c_TMR_W-1:0] w_last;
  logic               w_spd_up;
  logic               w_spd_dn;
  logic               w_tmr_clr;
  logic               w_tick;

  assign w_mult   = 4'd8 - {1'b0, speed_q};
  assign w_period = c_BASE * c_TMR_W'(w_mult);
  assign w_last   = w_period - c_TMR_W'(1);

  // Simultaneous faster and slower cancel each other entirely.
  assign w_spd_up = w_ev_faster & ~w_ev_slower;
  assign w_spd_dn = w_ev_slower & ~w_ev_faster;

  always_comb begin
    ctrl_d    = ctrl_q;
    speed_d   = speed_q;
    tmr_d     = tmr_q;
    w_tmr_clr = w_ev_run | w_spd_up | w_spd_dn;
    w_tick    = 1'b0;

    if (w_ev_run) begin
      ctrl_d = (ctrl_q == PAUSE) ? RUN : PAUSE;
    end

    if (w_spd_up && speed_q != 3'd7) begin
      speed_d = speed_q + 3'd1;
    end else if (w_spd_dn && speed_q != 3'd0) begin
      speed_d = speed_q - 3'd1;
    end

    // A clear (even from a saturated speed press) restarts the period and
    // suppresses any tick that would have landed in the same cycle.
    if (w_tmr_clr) begin
      tmr_d = '0;
    end else if (ctrl_q == RUN) begin
      if (tmr_q == w_last) begin
        w_tick = 1'b1;
        tmr_d  = '0;
      end else begin
        tmr_d = tmr_q + c_TMR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command FSM, pending flags and generation counter
  // --------------------------------------------------------------------------
  logic w_take_stamp;
  logic w_take_evolve;

  always_comb begin
    cmd_d         = IDLE;
    w_take_stamp  = 1'b0;
    w_take_evolve = 1'b0;

    case (cmd_q)
      IDLE: begin
        if (stamp_q) begin
          cmd_d        = STAMP;
          w_take_stamp = 1'b1;
        end else if (tick_q || step_q) begin
          cmd_d         = EVOLVE;
          w_take_evolve = 1'b1;
        end
      end
      // Both commands are single-cycle and always fall back to IDLE, which
      // guarantees an IDLE cycle between consecutive pulses.
      EVOLVE:  cmd_d = IDLE;
      STAMP:   cmd_d = IDLE;
      default: cmd_d = IDLE;
    endcase
  end

  always_comb begin
    stamp_d = (stamp_q & ~w_take_stamp) | w_ev_stamp;

    // A tick is always latched first and issued from IDLE, so one arriving
    // during a pulse or behind a stamp waits instead of being lost.
    if (w_ev_run && ctrl_q == RUN) begin
      tick_d = 1'b0;
    end else begin
      tick_d = (tick_q & ~w_take_evolve) | w_tick;
    end

    if (w_ev_run && ctrl_q == PAUSE) begin
      step_d = 1'b0;
    end else begin
      step_d = (step_q & ~w_take_evolve) | (w_ev_step & (ctrl_q == PAUSE));
    end

    gen_d = w_take_evolve ? gen_q + GEN_W'(1) : gen_q;
  end

  // Outputs decode straight from the registered command state so the
  // asynchronous reset ends a pulse immediately.
  always_comb begin
    bus.draw       = 1'b1;
    bus.freeze     = 1'b1;
    if (cmd_q == STAMP)  bus.draw   = 1'b0;
    if (cmd_q == EVOLVE) bus.freeze = 1'b0;
    bus.running    = (ctrl_q == RUN);
    bus.speed      = speed_q;
    bus.generation = gen_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_scheduler
// Description : Scoreboard bench for gen_scheduler (BASE_DIV=4, GEN_W=4).
//               Stimulus pushes expected draw/freeze pulses into a queue; a
//               negedge monitor pops and compares each pulse the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_scheduler;

  localparam int c_B_RUN    = 0;
  localparam int c_B_STEP   = 1;
  localparam int c_B_STAMP  = 2;
  localparam int c_B_FASTER = 3;
  localparam int c_B_SLOWER = 4;

  typedef struct {
    bit         stamp;
    logic [3:0] gen;
    int         gap;   // cycles since previous pulse, 0 = not checked
  } exp_t;

  logic clk;
  logic rst;

  gen_scheduler_if #(.GEN_W(4)) bus ();

  gen_scheduler #(
    .BASE_DIV (4),
    .GEN_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   pulse_cnt = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push_exp(input bit stamp, input int gen, input int gap);
    exp_t e;
    e.stamp = stamp;
    e.gen   = 4'(gen);
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // One short press: high for one cycle, low for one cycle.
  task automatic press(input int which);
    case (which)
      c_B_RUN:    bus.run_btn    = 1'b1;
      c_B_STEP:   bus.step_btn   = 1'b1;
      c_B_STAMP:  bus.stamp_btn  = 1'b1;
      c_B_FASTER: bus.faster_btn = 1'b1;
      default:    bus.slower_btn = 1'b1;
    endcase
    @(negedge clk);
    bus.run_btn    = 1'b0;
    bus.step_btn   = 1'b0;
    bus.stamp_btn  = 1'b0;
    bus.faster_btn = 1'b0;
    bus.slower_btn = 1'b0;
    @(negedge clk);
  endtask

  // Returns on the negedge one cycle after the pulse that reaches target.
  task automatic wait_cnt(input int target, input int budget);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (pulse_cnt < target) begin
      n_checks++;
      $display("FAIL pulse wait timeout: got %0d pulses, expected %0d", pulse_cnt, target);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- monitor
  int   cyc        = 0;
  int   last_cyc   = 0;
  bit   last_valid = 1'b0;
  int   gap;
  bit   act_stamp;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      last_valid = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (bus.draw === 1'b0 && bus.freeze === 1'b0) begin
        n_checks++;
        $display("FAIL draw/freeze both low at cycle %0d: got 0/0, expected never", cyc);
      end else if (bus.draw === 1'b0 || bus.freeze === 1'b0) begin
        act_stamp = (bus.draw === 1'b0);
        gap       = cyc - last_cyc;
        pulse_cnt++;
        if (last_valid) chk("pulse spacing>=2", gap >= 2, 1);
        last_cyc   = cyc;
        last_valid = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected pulse: got stamp=%0d gen=%0d, expected none", act_stamp, bus.generation);
        end else begin
          cur = exp_q.pop_front();
          chk("pulse kind(stamp)", act_stamp, cur.stamp);
          chk("pulse generation", bus.generation, cur.gen);
          if (cur.gap != 0) chk("pulse gap", gap, cur.gap);
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  int base;
  int n;

  initial begin
    rst            = 1'b0;
    bus.run_btn    = 1'b0;
    bus.step_btn   = 1'b0;
    bus.stamp_btn  = 1'b0;
    bus.faster_btn = 1'b0;
    bus.slower_btn = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset draw",       bus.draw,       1);
    chk("reset freeze",     bus.freeze,     1);
    chk("reset running",    bus.running,    0);
    chk("reset speed",      bus.speed,      3);
    chk("reset generation", bus.generation, 0);
    rst = 1'b1;

    repeat (1000) @(negedge clk);
    chk("idle draw",       bus.draw,       1);
    chk("idle freeze",     bus.freeze,     1);
    chk("idle speed",      bus.speed,      3);
    chk("idle generation", bus.generation, 0);

    // Step while paused, then stamp while paused
    push_exp(1'b0, 1, 0);
    base = pulse_cnt;
    press(c_B_STEP);
    wait_cnt(base + 1, 50);

    push_exp(1'b1, 1, 0);
    base = pulse_cnt;
    press(c_B_STAMP);
    wait_cnt(base + 1, 50);

    // Run at speed 3: period 20; a step pressed in RUN must add nothing
    push_exp(1'b0, 2, 0);
    push_exp(1'b0, 3, 20);
    push_exp(1'b0, 4, 20);
    base = pulse_cnt;
    press(c_B_RUN);
    press(c_B_STEP);
    wait_cnt(base + 3, 200);
    chk("running after run", bus.running, 1);

    // Five faster presses: saturate at 7, period 4
    push_exp(1'b0, 5, 0);
    for (int g = 6; g <= 12; g++) push_exp(1'b0, g, 4);
    base = pulse_cnt;
    repeat (5) press(c_B_FASTER);
    wait_cnt(base + 8, 200);
    chk("speed after faster", bus.speed, 7);

    // Eight slower presses: the tick already pending issues one more pulse,
    // then period 32; generation wraps 15 -> 0
    push_exp(1'b0, 13, 4);
    push_exp(1'b0, 14, 0);
    push_exp(1'b0, 15, 32);
    push_exp(1'b0, 0,  32);
    base = pulse_cnt;
    repeat (8) press(c_B_SLOWER);
    wait_cnt(base + 4, 300);
    chk("speed after slower", bus.speed, 0);

    // Stamp event lands in the same cycle as a tick
    push_exp(1'b1, 0, 32);
    push_exp(1'b0, 1, 2);
    base = pulse_cnt;
    repeat (27) @(negedge clk);
    press(c_B_STAMP);
    wait_cnt(base + 2, 100);

    // Pause: no further pulses
    press(c_B_RUN);
    repeat (80) @(negedge clk);
    chk("running after pause", bus.running, 0);

    push_exp(1'b0, 2, 0);
    base = pulse_cnt;
    press(c_B_STEP);
    wait_cnt(base + 1, 50);

    // Reset asserted in the middle of an evolve pulse
    push_exp(1'b0, 3, 0);
    press(c_B_STEP);
    n = 0;
    while (bus.freeze !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("evolve seen before reset", bus.freeze, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid-pulse reset freeze",     bus.freeze,     1);
    chk("mid-pulse reset draw",       bus.draw,       1);
    chk("mid-pulse reset generation", bus.generation, 0);
    chk("mid-pulse reset speed",      bus.speed,      3);

    // Run button held high through reset release must not toggle run
    @(negedge clk);
    bus.run_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("held button after reset", bus.running, 0);
    bus.run_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("held button released", bus.running, 0);

    chk("expected pulses all seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
